// File: rtl/bullet_pool_engine.sv
// Multi-slot falling-bullet sprite engine. Each frame tick, every live slot is serviced in turn:
// erase its block, move it down, then redraw it or free the slot. Emits one pixel write per cycle.
module bullet_pool_engine #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned BW          = 2,
  parameter int unsigned BH          = 3,
  parameter int unsigned SPEED       = 1,
  parameter int unsigned Y_LIMIT     = 118
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   fire,
  input  logic [7:0]             fire_x,
  input  logic [6:0]             fire_y,
  input  logic [2:0]             color_in,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [2:0]             color_out,
  output logic                   writeEn,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic                   fire_ack,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int unsigned IdxW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BULLETS - 1);
  localparam logic [2:0] LastCol = 3'(BW - 1);
  localparam logic [2:0] LastRow = 3'(BH - 1);

  typedef enum logic [2:0] {StIdle, StScan, StErase, StMove, StDraw, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [2:0]             col_q, col_d, row_q, row_d;
  logic [NUM_BULLETS-1:0] valid_q, valid_d;
  logic [7:0]             bx_q [NUM_BULLETS];
  logic [7:0]             bx_d [NUM_BULLETS];
  logic [6:0]             by_q [NUM_BULLETS];
  logic [6:0]             by_d [NUM_BULLETS];
  logic                   tick_pend_q, tick_pend_d, fire_pend_q, fire_pend_d;
  logic [7:0]             fx_q, fx_d;
  logic [6:0]             fy_q, fy_d;
  logic [7:0]             x_q, x_d;
  logic [6:0]             y_q, y_d;
  logic [2:0]             color_q, color_d;
  logic                   we_q, we_d, ack_q, ack_d, done_q, done_d, ovr_q, ovr_d;

  logic                   tick_take, fire_take, emit, found, last_pix;
  logic [IdxW-1:0]        free_idx;
  logic [7:0]             ny;
  logic [6:0]             ybase;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    col_d     = col_q;
    row_d     = row_q;
    valid_d   = valid_q;
    bx_d      = bx_q;
    by_d      = by_q;
    ack_d     = 1'b0;
    color_d   = 3'b000;
    tick_take = 1'b0;
    fire_take = 1'b0;
    emit      = 1'b0;
    ybase     = by_q[idx_q];
    ny        = {1'b0, by_q[idx_q]} + 8'(SPEED);
    last_pix  = (col_q == LastCol) && (row_q == LastRow);

    found    = 1'b0;
    free_idx = '0;
    for (int i = int'(NUM_BULLETS) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        found    = 1'b1;
        free_idx = IdxW'(i);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (fire_pend_q) begin
          fire_take = 1'b1;
          if (found) begin
            valid_d[free_idx] = 1'b1;
            bx_d[free_idx]    = fx_q;
            by_d[free_idx]    = fy_q;
            ack_d             = 1'b1;
          end
        end else if (tick_pend_q) begin
          tick_take = 1'b1;
          idx_d     = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (valid_q[idx_q]) begin
          state_d = StErase;
          col_d   = '0;
          row_d   = '0;
          emit    = 1'b1;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StErase, StDraw: begin
        if (last_pix) begin
          if (state_q == StErase) begin
            state_d = StMove;
          end else if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StScan;
          end
        end else begin
          emit    = 1'b1;
          color_d = (state_q == StDraw) ? color_in : 3'b000;
          if (col_q == LastCol) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      StMove: begin
        if (ny >= 8'(Y_LIMIT)) begin
          valid_d[idx_q] = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StScan;
          end
        end else begin
          by_d[idx_q] = ny[6:0];
          ybase       = ny[6:0];
          state_d     = StDraw;
          col_d       = '0;
          row_d       = '0;
          emit        = 1'b1;
          color_d     = color_in;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Output registers carry the pixel belonging to the state being entered.
    we_d   = emit;
    x_d    = emit ? (bx_q[idx_q] + {5'd0, col_d}) : 8'd0;
    y_d    = emit ? (ybase + {4'd0, row_d}) : 7'd0;
    done_d = (state_d == StDone);

    // A new request arriving on the consuming edge survives; last fire wins.
    tick_pend_d = tick | (tick_pend_q & ~tick_take);
    fire_pend_d = fire | (fire_pend_q & ~fire_take);
    fx_d        = fire ? fire_x : fx_q;
    fy_d        = fire ? fire_y : fy_q;
    ovr_d       = ovr_q | (tick & tick_pend_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      valid_q     <= '0;
      bx_q        <= '{default: '0};
      by_q        <= '{default: '0};
      tick_pend_q <= 1'b0;
      fire_pend_q <= 1'b0;
      fx_q        <= '0;
      fy_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      color_q     <= '0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      valid_q     <= valid_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      tick_pend_q <= tick_pend_d;
      fire_pend_q <= fire_pend_d;
      fx_q        <= fx_d;
      fy_q        <= fy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign color_out   = color_q;
  assign writeEn     = we_q;
  assign active_mask = valid_q;
  assign fire_ack    = ack_q;
  assign frame_done  = done_q;
  assign overrun     = ovr_q;

endmodule
